// File: rtl/program_mem.sv
// Loadable shared instruction memory with round-robin fetch ports and a registered one-cycle read.
// Optional PROGRAM_MEM_RELOAD_EN lets load_start return the block from RUN to LOAD.
module program_mem #(
  parameter int DEPTH     = 64,
  parameter int NUM_PORTS = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load_valid,
  input  logic [7:0]              load_data,
  input  logic                    load_last,
  output logic                    load_ready,
  input  logic                    load_start,
  output logic                    busy,
  input  logic [NUM_PORTS-1:0]    rd_req,
  input  logic [NUM_PORTS*32-1:0] rd_addr,
  output logic [NUM_PORTS-1:0]    rd_ack,
  output logic [NUM_PORTS*32-1:0] rd_data,
  output logic [NUM_PORTS-1:0]    rd_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = $clog2(DEPTH + 1);
  localparam int RW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                    r_state;
  logic [PW-1:0]             r_wptr;
  logic [1:0]                r_lane;
  logic [23:0]               r_bytes;
  logic [RW-1:0]             r_rr;
  logic [NUM_PORTS-1:0]      r_rd_ack;
  logic [NUM_PORTS*32-1:0]   r_rd_data;
  logic [NUM_PORTS-1:0]      r_rd_err;
  logic [31:0]               r_mem [DEPTH];

  logic                      w_load_acc;
  logic                      w_word_done;
  logic [PW-1:0]             w_ptr_next;
  logic                      w_ptr_full;
  logic [31:0]               w_wdata;
  logic [NUM_PORTS-1:0]      w_elig;
  logic [NUM_PORTS-1:0]      w_grant;
  logic                      w_found;
  logic [RW-1:0]             w_gidx;
  logic [RW-1:0]             w_idx;
  logic [RW-1:0]             w_rr_next;
  logic [31:0]               w_gaddr;
  logic                      w_oor;
  logic [31:0]               w_rdata;
  logic                      w_unused;

  assign load_ready  = (r_state == ST_LOAD);
  assign busy        = (r_state == ST_LOAD);
  assign rd_ack      = r_rd_ack;
  assign rd_data     = r_rd_data;
  assign rd_err      = r_rd_err;

  assign w_load_acc  = load_valid & (r_state == ST_LOAD);
  assign w_word_done = w_load_acc & (load_last | (r_lane == 2'd3));
  assign w_ptr_next  = r_wptr + {{(PW-1){1'b0}}, 1'b1};
  assign w_ptr_full  = (w_ptr_next == PW'(DEPTH));
  assign w_unused    = ^{w_gaddr[1:0], load_start};

  // Assemble the little-endian word; lanes not yet filled read as zero.
  always_comb begin
    w_wdata = 32'h0000_0000;
    case (r_lane)
      2'd0:    w_wdata = {24'h00_0000, load_data};
      2'd1:    w_wdata = {16'h0000, load_data, r_bytes[7:0]};
      2'd2:    w_wdata = {8'h00, load_data, r_bytes[15:0]};
      default: w_wdata = {load_data, r_bytes};
    endcase
  end

  // Round-robin pick of the first eligible port at or after the pointer.
  always_comb begin
    w_found = 1'b0;
    w_gidx  = {RW{1'b0}};
    w_idx   = {RW{1'b0}};
    w_grant = {NUM_PORTS{1'b0}};
    w_elig  = rd_req & ~r_rd_ack;
    if (r_state == ST_RUN) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        w_idx = RW'((int'(r_rr) + i) % NUM_PORTS);
        if (!w_found && w_elig[w_idx]) begin
          w_found = 1'b1;
          w_gidx  = w_idx;
        end else begin
          w_gidx  = w_gidx;
        end
      end
      w_grant[w_gidx] = w_found;
    end else begin
      w_found = 1'b0;
    end
  end

  assign w_rr_next = (w_gidx == RW'(NUM_PORTS - 1)) ? {RW{1'b0}} : (w_gidx + RW'(1));
  assign w_gaddr   = rd_addr[32*w_gidx +: 32];
  assign w_oor     = (w_gaddr[31:2] >= 30'(DEPTH));
  assign w_rdata   = w_oor ? 32'h0000_0013 : r_mem[w_gaddr[AW+1:2]];

  // Word array has no reset so contents survive reset and reload.
  always_ff @(posedge clk) begin
    if (w_word_done && !reset) begin
      r_mem[r_wptr[AW-1:0]] <= w_wdata;
    end
  end

  // Load/run state machine plus registered read responses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_LOAD;
      r_wptr    <= {PW{1'b0}};
      r_lane    <= 2'd0;
      r_bytes   <= 24'h00_0000;
      r_rr      <= {RW{1'b0}};
      r_rd_ack  <= {NUM_PORTS{1'b0}};
      r_rd_data <= {(NUM_PORTS*32){1'b0}};
      r_rd_err  <= {NUM_PORTS{1'b0}};
    end else begin
      r_rd_ack <= w_grant;
      if (w_found) begin
        r_rd_data[32*w_gidx +: 32] <= w_rdata;
        r_rd_err[w_gidx]           <= w_oor;
        r_rr                       <= w_rr_next;
      end
      case (r_state)
        ST_LOAD: begin
          if (w_word_done) begin
            r_wptr  <= w_ptr_next;
            r_lane  <= 2'd0;
            r_bytes <= 24'h00_0000;
            if (load_last || w_ptr_full) begin
              r_state <= ST_RUN;
            end
          end else if (w_load_acc) begin
            r_lane <= r_lane + 2'd1;
            case (r_lane)
              2'd0:    r_bytes[7:0]   <= load_data;
              2'd1:    r_bytes[15:8]  <= load_data;
              default: r_bytes[23:16] <= load_data;
            endcase
          end
        end
        ST_RUN: begin
`ifdef PROGRAM_MEM_RELOAD_EN
          if (load_start) begin
            r_state <= ST_LOAD;
            r_wptr  <= {PW{1'b0}};
            r_lane  <= 2'd0;
            r_bytes <= 24'h00_0000;
          end
`else
          r_state <= ST_RUN;
`endif
        end
        default: r_state <= ST_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_program_mem.sv
// Directed self-checking bench for program_mem (DEPTH=64, NUM_PORTS=2).
module tb_program_mem;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_valid;
  logic [7:0]  load_data;
  logic        load_last;
  logic        load_ready;
  logic        load_start;
  logic        busy;
  logic [1:0]  rd_req;
  logic [63:0] rd_addr;
  logic [1:0]  rd_ack;
  logic [63:0] rd_data;
  logic [1:0]  rd_err;

  int n_tests = 0;
  int n_fail  = 0;

  program_mem #(.DEPTH(64), .NUM_PORTS(2)) dut (
    .clk(clk), .reset(reset),
    .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
    .load_ready(load_ready), .load_start(load_start), .busy(busy),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
    .rd_data(rd_data), .rd_err(rd_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_byte(input logic [7:0] b, input logic last);
    load_valid = 1'b1;
    load_data  = b;
    load_last  = last;
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic read_one(input string tag, input int port, input logic [31:0] addr,
                          input logic [31:0] exp_data, input logic exp_err);
    logic [1:0] onehot;
    onehot = 2'b01 << port;
    rd_addr[32*port +: 32] = addr;
    rd_req[port] = 1'b1;
    tick();
    check({tag, " ack"}, {30'd0, rd_ack}, {30'd0, onehot});
    check({tag, " data"}, rd_data[32*port +: 32], exp_data);
    check({tag, " err"}, {31'd0, rd_err[port]}, {31'd0, exp_err});
    rd_req[port] = 1'b0;
    tick();
    check({tag, " ack clear"}, {30'd0, rd_ack}, 32'd0);
  endtask

  initial begin
    logic [7:0] img [8];
    img = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h02, 8'h10, 8'h00};
    reset = 1'b1; load_valid = 1'b0; load_data = 8'h00; load_last = 1'b0;
    load_start = 1'b0; rd_req = 2'b00; rd_addr = 64'd0;
    tick(); tick();
    reset = 1'b0;
    tick();
    check("rst busy", {31'd0, busy}, 32'd1);
    check("rst load_ready", {31'd0, load_ready}, 32'd1);
    check("rst ack", {30'd0, rd_ack}, 32'd0);
    check("rst data0", rd_data[31:0], 32'd0);
    check("rst data1", rd_data[63:32], 32'd0);
    check("rst err", {30'd0, rd_err}, 32'd0);

    // Two-word image, last on byte 8
    for (int i = 0; i < 8; i++) begin
      load_byte(img[i], (i == 7));
      if (i == 6) check("busy mid-load", {31'd0, busy}, 32'd1);
    end
    check("busy after load", {31'd0, busy}, 32'd0);
    check("load_ready run", {31'd0, load_ready}, 32'd0);

    read_one("p0 addr0", 0, 32'd0, 32'h0000_0013, 1'b0);
    read_one("p0 addr4", 0, 32'd4, 32'h0010_0293, 1'b0);
    read_one("p1 addr6", 1, 32'd6, 32'h0010_0293, 1'b0);
    read_one("p0 oor", 0, 32'd256, 32'h0000_0013, 1'b1);
    read_one("p1 addr0", 1, 32'd0, 32'h0000_0013, 1'b0);

    // Both ports requesting continuously must alternate with no gaps
    rd_addr = {32'd4, 32'd0};
    rd_req  = 2'b11;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("rr ack", {30'd0, rd_ack}, (i % 2 == 0) ? 32'd1 : 32'd2);
    end
    check("rr data0", rd_data[31:0], 32'h0000_0013);
    check("rr data1", rd_data[63:32], 32'h0010_0293);
    rd_req = 2'b00;
    tick();

    // Reset during an in-flight ack
    rd_addr[31:0] = 32'd0;
    rd_req = 2'b01;
    tick();
    check("pre-reset ack", {30'd0, rd_ack}, 32'd1);
    reset = 1'b1;
    #1;
    check("reset drops ack", {30'd0, rd_ack}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd1);
    check("reset load_ready", {31'd0, load_ready}, 32'd1);
    check("reset data", rd_data[31:0], 32'd0);
    tick();
    reset = 1'b0;
    tick();
    check("no ack in load", {30'd0, rd_ack}, 32'd0);
    load_byte(8'h01, 1'b0);
    load_byte(8'h02, 1'b0);
    load_byte(8'h03, 1'b0);
    load_byte(8'h04, 1'b0);
    check("partial still loading", {31'd0, busy}, 32'd1);
    load_byte(8'hAB, 1'b1);
    check("run on 5th byte", {31'd0, busy}, 32'd0);
    check("no ack same edge", {30'd0, rd_ack}, 32'd0);
    tick();
    check("held req ack", {30'd0, rd_ack}, 32'd1);
    check("held req data", rd_data[31:0], 32'h0403_0201);
    rd_addr[31:0] = 32'd4;
    tick();
    check("ineligible after ack", {30'd0, rd_ack}, 32'd0);
    tick();
    check("partial ack", {30'd0, rd_ack}, 32'd1);
    check("partial word", rd_data[31:0], 32'h0000_00AB);
    check("partial err", {30'd0, rd_err}, 32'd0);
    rd_req = 2'b00;
    tick();

    // load_start in RUN
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
`ifdef PROGRAM_MEM_RELOAD_EN
    check("reload busy", {31'd0, busy}, 32'd1);
    load_byte(8'h78, 1'b0);
    load_byte(8'h56, 1'b0);
    load_byte(8'h34, 1'b0);
    load_byte(8'h12, 1'b1);
    check("reload done", {31'd0, busy}, 32'd0);
    read_one("reload w0", 0, 32'd0, 32'h1234_5678, 1'b0);
    read_one("reload w1 kept", 0, 32'd4, 32'h0000_00AB, 1'b0);
`else
    check("no reload busy", {31'd0, busy}, 32'd0);
    check("no reload ready", {31'd0, load_ready}, 32'd0);
    read_one("no reload w0", 0, 32'd0, 32'h0403_0201, 1'b0);
`endif

    // Filling every word ends the load without load_last
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 256; i++) begin
      load_byte(i[7:0], 1'b0);
      if (i == 254) check("full busy", {31'd0, busy}, 32'd1);
    end
    check("full run", {31'd0, busy}, 32'd0);
    load_valid = 1'b1;
    load_data  = 8'h55;
    #1;
    check("full not ready", {31'd0, load_ready}, 32'd0);
    tick();
    load_valid = 1'b0;
    read_one("full w63", 0, 32'd252, 32'hFFFE_FDFC, 1'b0);
    read_one("full w2", 1, 32'd8, 32'h0B0A_0908, 1'b0);
    read_one("full w0", 0, 32'd0, 32'h0302_0100, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/program_mem.md
# program_mem

Parametrised, loadable instruction memory that serves multiple RV32E cores from one shared word array. After reset it is filled over a byte-wide load stream, then switches to run mode. In run mode it arbitrates per-core fetch requests round-robin with a registered one-cycle read. It replaces the fixed, reset-initialised program ROM at the processor-array fetch boundary.

## Interface
- DEPTH, 64: number of 32-bit words; word index = addr[31:2].
- NUM_PORTS, 2: number of core fetch ports (≥1).
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- load_valid  in  1  load byte present.
- load_data  in  8  load byte.
- load_last  in  1  qualifies final byte of the image (with load_valid).
- load_ready  out  1  loader accepts a byte this cycle.
- load_start  in  1  re-enter load mode (see Configuration).
- busy  out  1  high while in LOAD state.
- rd_req  in  NUM_PORTS  per-port fetch request (level, held until ack).
- rd_addr  in  NUM_PORTS*32  per-port byte address, port k at [32k+31:32k].
- rd_ack  out  NUM_PORTS  one-cycle per-port completion pulse.
- rd_data  out  NUM_PORTS*32  per-port fetched word, registered.
- rd_err  out  NUM_PORTS  per-port out-of-range flag, valid with rd_ack.

## Operation
- States: LOAD, RUN. Reset → LOAD, write pointer 0, byte lane 0, round-robin pointer 0.
- LOAD: load_ready=1. Each accepted byte (load_valid & load_ready) fills lane 0..3, little-endian. When lane 3 is accepted, the word is written at the pointer, the pointer increments and the lane returns to 0.
- load_last on a byte ends the load. A partial word is written with its unfilled upper bytes zeroed. State then → RUN.
- Pointer reaching DEPTH after a word write → RUN regardless of load_last. Further bytes are not accepted.
- RUN: load_ready=0. Requests are served; no requests are acked in LOAD, and pending requests wait.
- Arbitration: the first requesting port at or after the round-robin pointer is granted, one grant per cycle. After granting port k the pointer becomes (k+1) mod NUM_PORTS. A port is not eligible in the cycle its rd_ack is high.
- Address: addr[1:0] ignored (forced word alignment). If addr[31:2] ≥ DEPTH, rd_data=32'h00000013 (ADDI x0,x0,0) and rd_err=1. Otherwise the stored word is returned with rd_err=0.
- Memory contents are not cleared by reset. Words beyond the loaded image keep their prior values, which are undefined after power-up.

## Timing
- Reset values: state LOAD, busy=1, load_ready=1, rd_ack=0, rd_data=0, rd_err=0.
- Read latency: a request granted at edge N gives rd_ack=1 with rd_data/rd_err in the cycle after N (one clock). rd_data and rd_err hold until that port's next ack.
- Throughput: one read per cycle aggregate. One read per 2 cycles per port.
- LOAD→RUN: takes effect on the edge that accepts the final byte. Requests are first eligible for grant on the following edge.
- Reset asserted mid-load or mid-read: immediate return to reset values. An in-flight ack is dropped and the requesting port must keep rd_req high to be re-served.

## Configuration
- PROGRAM_MEM_RELOAD_EN defined: load_start=1 in RUN moves the block to LOAD on the next edge, with pointer and lane cleared. A grant issued on that same edge still completes its ack.
- PROGRAM_MEM_RELOAD_EN undefined: load_start is ignored. Only reset returns the block to LOAD.

## Test plan
- Load 8 bytes 13 00 00 00 93 02 10 00, last on the 8th → busy falls. Port 0 reads addr 0 → 32'h00000013; addr 4 → 32'h00100293. Each is acked one cycle after grant.
- Load 5 bytes ending with load_last → word 1 = 32'h000000XX (upper 3 bytes zero), where XX is the 5th byte. RUN entered on the 5th byte.
- NUM_PORTS=2, both ports request continuously in RUN → acks alternate port 0, port 1, port 0, … with no cycle lacking an ack.
- Read addr DEPTH*4 (e.g. 256 with DEPTH=64) → rd_data=32'h00000013, rd_err=1. addr 6 reads word 1 with rd_err=0.
- Assert reset during a granted read → no rd_ack, busy=1, load_ready=1. A re-load followed by a held request then completes.
- With PROGRAM_MEM_RELOAD_EN: pulse load_start in RUN → busy=1 and the next load overwrites from word 0. Without it: busy stays 0.
